// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain programmer.
// FSM state encoding and a constant log2 helper.
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        MARK,
        LOAD,
        DONE
    } ccff_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-entry bitstream word buffer, LSB-first.
// An empty buffer can pass the incoming word's bit 0 straight through.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_en,
    input  logic              consume,
    input  logic              last,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              bit_avail,
    output logic              bit_out
);

    localparam int IDX_W = (WORD_W > 1) ? clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_NEXT = (WORD_W > 1) ? IDX_W'(1) : IDX_W'(0);
    localparam logic WRAPS_NOW = (WORD_W == 1);

    logic [WORD_W-1:0] buf_q;
    logic [IDX_W-1:0]  idx_q;
    logic              full_q;

    assign word_ready = accept_en & ~full_q;
    assign bit_avail  = full_q | (word_valid & word_ready);
    assign bit_out    = full_q ? buf_q[idx_q] : word_data[0];

    // Buffer fill, bit stepping and release after the top bit or final shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (consume) begin
            if (last) begin
                full_q <= 1'b0;
                idx_q  <= '0;
            end else if (full_q) begin
                if (idx_q == IDX_LAST) begin
                    full_q <= 1'b0;
                    idx_q  <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                buf_q  <= word_data;
                full_q <= ~WRAPS_NOW;
                idx_q  <= IDX_NEXT;
            end
        end else if (word_valid && word_ready) begin
            buf_q  <= word_data;
            full_q <= 1'b1;
            idx_q  <= '0;
        end
    end

endmodule

// File: rtl/ccff_chain_programmer.sv
// Serial write driver for the ccff configuration chain.
// Flushes, shifts a marker, loads data and checks chain length at the tail.
module ccff_chain_programmer
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 8,
    parameter int FLUSH_EN  = 1
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              chain_ok
);

    localparam int CNT_W = clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] K_HI    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] FL_END  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] K_TWO   = CNT_W'(2);
    localparam logic             DO_FL   = (FLUSH_EN != 0);

    ccff_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] k_issue;
    logic             clk_en_q;
    logic             head_q;
    logic             fail_q;
    logic             ok_q;
    logic             rst_dly_q;

    logic start_ok;
    logic draining;
    logic issue;
    logic issue_bit;
    logic accept_en;
    logic consume;
    logic last_shift;
    logic viol;
    logic fail_d;
    logic ser_avail;
    logic ser_bit;

    assign start_ok   = start & ~rst_dly_q;
    assign draining   = (state_q == LOAD) && (cnt_q == K_LAST);
    assign last_shift = consume && (cnt_q == K_HI);

    ccff_word_serializer #(
        .WORD_W(WORD_W)
    ) u_ser (
        .clk        (prog_clk),
        .rst        (pReset),
        .accept_en  (accept_en),
        .consume    (consume),
        .last       (last_shift),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .bit_avail  (ser_avail),
        .bit_out    (ser_bit)
    );

    // State register
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = DO_FL ? FLUSH : MARK;
            FLUSH:   if (cnt_q == FL_END) state_d = MARK;
            MARK:    state_d = LOAD;
            LOAD:    if (draining) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state shift issue, word acceptance and status decode
    always_comb begin
        issue     = 1'b0;
        issue_bit = 1'b0;
        k_issue   = '0;
        accept_en = 1'b0;
        consume   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            FLUSH: begin
                issue     = 1'b1;
                accept_en = 1'b1;
                busy      = 1'b1;
            end
            MARK: begin
                issue     = 1'b1;
                issue_bit = 1'b1;
                k_issue   = CNT_W'(1);
                accept_en = 1'b1;
                busy      = 1'b1;
            end
            LOAD: begin
                busy      = 1'b1;
                accept_en = ~draining;
                consume   = ~draining & ser_avail;
                issue     = consume;
                issue_bit = ser_bit;
                k_issue   = cnt_q + 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Tail check on each presented shift; k=0 marks flush shifts
    always_comb begin
        viol = 1'b0;
        if (clk_en_q) begin
            if (k_q == K_LAST && !ccff_tail) viol = 1'b1;
            if (DO_FL && k_q >= K_TWO && k_q <= K_HI && ccff_tail) viol = 1'b1;
        end
        fail_d = fail_q | viol;
    end

    // Shift counter, registered chain drive and pass/fail latch
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            cnt_q     <= '0;
            k_q       <= '0;
            clk_en_q  <= 1'b0;
            head_q    <= 1'b0;
            fail_q    <= 1'b0;
            ok_q      <= 1'b0;
            rst_dly_q <= 1'b1;
        end else begin
            rst_dly_q <= 1'b0;
            clk_en_q  <= issue;
            if (issue) begin
                head_q <= issue_bit;
                k_q    <= k_issue;
            end
            if (state_q == FLUSH) begin
                cnt_q <= (cnt_q == FL_END) ? '0 : cnt_q + 1'b1;
            end else if (state_q == MARK) begin
                cnt_q <= CNT_W'(1);
            end else if (consume) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == DONE) begin
                cnt_q <= '0;
            end
            if (state_q == IDLE && start_ok) begin
                fail_q <= 1'b0;
                ok_q   <= 1'b0;
            end else begin
                fail_q <= fail_d;
                if (draining) ok_q <= ~fail_d;
            end
        end
    end

    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign chain_ok    = ok_q;

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Directed bench for ccff_chain_programmer.
// Behavioural chains on the gated clock feed ccff_tail back.
module tb_ccff_chain_programmer;

    localparam logic [29:0] EXP_CHAIN = 30'b101001010011110011111111010010;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start;
    logic       word_valid;
    logic [7:0] word_data;
    logic       word_ready;
    logic       ccff_head;
    logic       ccff_clk_en;
    logic       ccff_tail;
    logic       busy;
    logic       done;
    logic       chain_ok;

    logic       b_start;
    logic       b_valid;
    logic [3:0] b_data;
    logic       b_ready;
    logic       b_head;
    logic       b_clk_en;
    logic       b_tail;
    logic       b_busy;
    logic       b_done;
    logic       b_ok;

    logic [31:0] chain_m;
    logic [4:0]  tail_idx;
    logic        model_fill;
    logic [4:0]  chain_b;

    logic [7:0] wl [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h12};

    int total = 0;
    int bad = 0;

    int   r_sh, r_gap, r_first, r_last, r_done_c, r_widx;
    logic r_saw, r_ok, r_busy_done, r_busy0, r_busy1;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_programmer #(
        .CHAIN_LEN(30), .WORD_W(8), .FLUSH_EN(1)
    ) dut (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (start),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .chain_ok    (chain_ok)
    );

    ccff_chain_programmer #(
        .CHAIN_LEN(5), .WORD_W(4), .FLUSH_EN(0)
    ) dut_b (
        .prog_clk    (prog_clk),
        .pReset      (pReset),
        .start       (b_start),
        .word_valid  (b_valid),
        .word_data   (b_data),
        .word_ready  (b_ready),
        .ccff_head   (b_head),
        .ccff_clk_en (b_clk_en),
        .ccff_tail   (b_tail),
        .busy        (b_busy),
        .done        (b_done),
        .chain_ok    (b_ok)
    );

    assign ccff_tail = chain_m[tail_idx];
    assign b_tail    = chain_b[4];

    always @(posedge prog_clk) begin
        if (model_fill) chain_m <= '1;
        else if (ccff_clk_en) chain_m <= {chain_m[30:0], ccff_head};
    end

    always @(posedge prog_clk or posedge pReset) begin
        if (pReset) chain_b <= '0;
        else if (b_clk_en) chain_b <= {chain_b[3:0], b_head};
    end

    task automatic run_prog(input int stall_after, input int rst_at,
                            input bit start_busy, input bit start_at_done);
        int  stall_left;
        bit  pend;
        bit  fin;
        stall_left = 0;
        pend = 0;
        fin = 0;
        r_sh = 0; r_gap = 0; r_first = -1; r_last = -1; r_done_c = -1;
        r_widx = 0; r_saw = 0; r_ok = 1'bx; r_busy_done = 1'bx;
        r_busy0 = 1'bx; r_busy1 = 1'bx;
        model_fill = 1'b1;
        @(negedge prog_clk);
        model_fill = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge prog_clk);
            if (c == 0) r_busy0 = busy;
            if (c == 1) r_busy1 = busy;
            if (ccff_clk_en) begin
                if (r_first < 0) r_first = c;
                r_last = c;
                r_sh++;
            end else if (r_first >= 0 && !done) begin
                r_gap++;
            end
            if (done) begin
                r_saw = 1'b1;
                r_ok = chain_ok;
                r_busy_done = busy;
                r_done_c = c;
                fin = 1;
            end
            if (rst_at > 0 && r_sh == rst_at) fin = 1;
            if (pend && word_ready) begin
                stall_left = 5;
                pend = 0;
            end
            start = (c == 0) || (start_busy && c == 20) || (done && start_at_done);
            word_valid = (r_widx < 4) && (stall_left == 0);
            word_data = word_valid ? wl[r_widx] : 8'h00;
            if (word_valid && word_ready) begin
                r_widx++;
                if (r_widx == stall_after) pend = 1;
            end
            if (stall_left > 0) stall_left--;
        end
    endtask

    task automatic test_reset;
        pReset = 1'b1;
        start = 1'b0; word_valid = 1'b0; word_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 4'h0;
        model_fill = 1'b0; tail_idx = 5'd29;
        repeat (3) @(negedge prog_clk);
        total++;
        if ({ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok});
        end
        total++;
        if ({b_head, b_clk_en, b_ready, b_busy, b_done, b_ok} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs_b got=%b exp=000000",
                     {b_head, b_clk_en, b_ready, b_busy, b_done, b_ok});
        end
        pReset = 1'b0;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_at_reset_release busy=%b exp=0", busy);
        end
        @(negedge prog_clk);
        total++;
        if (ccff_clk_en !== 1'b0) begin
            bad++;
            $display("FAIL start_at_reset_release clk_en=%b exp=0", ccff_clk_en);
        end
    endtask

    task automatic test_basic;
        run_prog(0, 0, 0, 0);
        total++;
        if (r_saw !== 1'b1) begin bad++; $display("FAIL basic_done_seen got=%b exp=1", r_saw); end
        total++;
        if (r_sh !== 61) begin bad++; $display("FAIL basic_shifts got=%0d exp=61", r_sh); end
        total++;
        if (r_first !== 2) begin bad++; $display("FAIL basic_first_shift got=%0d exp=2", r_first); end
        total++;
        if (r_busy0 !== 1'b0 || r_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_start got=%b%b exp=01", r_busy0, r_busy1);
        end
        total++;
        if (r_done_c !== r_last + 1) begin
            bad++;
            $display("FAIL basic_done_latency got=%0d exp=%0d", r_done_c, r_last + 1);
        end
        total++;
        if (r_gap !== 0) begin bad++; $display("FAIL basic_gaps got=%0d exp=0", r_gap); end
        total++;
        if (r_ok !== 1'b1 || r_busy_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_ok_busy got=%b%b exp=10", r_ok, r_busy_done);
        end
        total++;
        if (chain_m[29:0] !== EXP_CHAIN) begin
            bad++;
            $display("FAIL basic_chain got=%b exp=%b", chain_m[29:0], EXP_CHAIN);
        end
        total++;
        if (r_widx !== 4) begin bad++; $display("FAIL basic_words got=%0d exp=4", r_widx); end
        @(negedge prog_clk);
        total++;
        if (chain_ok !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_ok_hold got=%b%b exp=10", chain_ok, done);
        end
    endtask

    task automatic test_bad_length;
        tail_idx = 5'd28;
        run_prog(0, 0, 0, 0);
        total++;
        if (r_saw !== 1'b1 || r_ok !== 1'b0) begin
            bad++;
            $display("FAIL short_chain saw=%b ok=%b exp saw=1 ok=0", r_saw, r_ok);
        end
        tail_idx = 5'd30;
        run_prog(0, 0, 0, 0);
        total++;
        if (r_saw !== 1'b1 || r_ok !== 1'b0) begin
            bad++;
            $display("FAIL long_chain saw=%b ok=%b exp saw=1 ok=0", r_saw, r_ok);
        end
        tail_idx = 5'd29;
    endtask

    task automatic test_stall;
        run_prog(2, 0, 0, 0);
        total++;
        if (r_gap !== 5) begin bad++; $display("FAIL stall_gaps got=%0d exp=5", r_gap); end
        total++;
        if (r_sh !== 61) begin bad++; $display("FAIL stall_shifts got=%0d exp=61", r_sh); end
        total++;
        if (chain_m[29:0] !== EXP_CHAIN) begin
            bad++;
            $display("FAIL stall_chain got=%b exp=%b", chain_m[29:0], EXP_CHAIN);
        end
        total++;
        if (r_saw !== 1'b1 || r_ok !== 1'b1) begin
            bad++;
            $display("FAIL stall_ok saw=%b ok=%b exp saw=1 ok=1", r_saw, r_ok);
        end
    endtask

    task automatic test_reset_mid;
        int act;
        run_prog(0, 42, 0, 0);
        total++;
        if (r_sh !== 42 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_reach shifts=%0d busy=%b exp 42 1", r_sh, busy);
        end
        #1 pReset = 1'b1;
        #1;
        total++;
        if ({ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok} !== 6'b0) begin
            bad++;
            $display("FAIL midrst_async got=%b exp=000000",
                     {ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok});
        end
        @(negedge prog_clk);
        total++;
        if ({ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok} !== 6'b0) begin
            bad++;
            $display("FAIL midrst_next got=%b exp=000000",
                     {ccff_head, ccff_clk_en, word_ready, busy, done, chain_ok});
        end
        start = 1'b0;
        word_valid = 1'b1;
        word_data = 8'hA5;
        pReset = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge prog_clk);
            if (ccff_clk_en || word_ready || busy) act++;
        end
        total++;
        if (act !== 0) begin bad++; $display("FAIL midrst_quiet got=%0d exp=0", act); end
        word_valid = 1'b0;
        run_prog(0, 0, 0, 0);
        total++;
        if (r_saw !== 1'b1 || r_ok !== 1'b1 || r_sh !== 61) begin
            bad++;
            $display("FAIL midrst_reprog saw=%b ok=%b shifts=%0d exp 1 1 61", r_saw, r_ok, r_sh);
        end
        total++;
        if (chain_m[29:0] !== EXP_CHAIN) begin
            bad++;
            $display("FAIL midrst_chain got=%b exp=%b", chain_m[29:0], EXP_CHAIN);
        end
    endtask

    task automatic test_ignored_start;
        int act;
        start = 1'b0;
        word_valid = 1'b1;
        word_data = 8'h3C;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge prog_clk);
            if (word_ready || busy || ccff_clk_en) act++;
        end
        total++;
        if (act !== 0) begin bad++; $display("FAIL idle_ready got=%0d exp=0", act); end
        word_valid = 1'b0;
        run_prog(0, 0, 1, 1);
        total++;
        if (r_saw !== 1'b1 || r_sh !== 61 || r_ok !== 1'b1) begin
            bad++;
            $display("FAIL busy_start saw=%b shifts=%0d ok=%b exp 1 61 1", r_saw, r_sh, r_ok);
        end
        @(negedge prog_clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || ccff_clk_en !== 1'b0) begin
            bad++;
            $display("FAIL done_start got=%b%b exp=00", busy, ccff_clk_en);
        end
        @(negedge prog_clk);
        total++;
        if (busy !== 1'b0 || word_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_start_idle got=%b%b exp=00", busy, word_ready);
        end
    endtask

    task automatic test_noflush;
        int  n;
        int  widx;
        bit  saw;
        bit  fin;
        logic ok;
        n = 0; widx = 0; saw = 0; fin = 0; ok = 1'bx;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge prog_clk);
            if (b_clk_en) n++;
            if (b_done) begin
                saw = 1;
                ok = b_ok;
                fin = 1;
            end
            b_start = (c == 0);
            b_valid = (widx < 2);
            b_data = (widx == 0) ? 4'h9 : (widx == 1) ? 4'h1 : 4'h0;
            if (b_valid && b_ready) widx++;
        end
        b_start = 1'b0;
        b_valid = 1'b0;
        total++;
        if (n !== 6) begin bad++; $display("FAIL noflush_shifts got=%0d exp=6", n); end
        total++;
        if (chain_b !== 5'b10011) begin
            bad++;
            $display("FAIL noflush_chain got=%b exp=10011", chain_b);
        end
        total++;
        if (saw !== 1'b1 || ok !== 1'b1 || widx !== 2) begin
            bad++;
            $display("FAIL noflush_ok saw=%b ok=%b words=%0d exp 1 1 2", saw, ok, widx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_length();
        test_stall();
        test_reset_mid();
        test_ignored_start();
        test_noflush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
